// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO result registers.
// One product or quotient bit per cycle: 32 RUN cycles, then a FIX cycle applies the signs.
module mult_div_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] in_a,
   input  logic [31:0] in_b,
   input  logic        write_hi,
   input  logic        write_lo,
   input  logic [31:0] write_data,
   output logic        busy,
   output logic        done,
   output logic        div_by_zero,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [4:0]  r_cnt;
   logic [63:0] r_acc;
   logic [31:0] r_opb;
   logic        r_is_div;
   logic        r_neg_a;
   logic        r_neg_b;
   logic [31:0] r_hi;
   logic [31:0] r_lo;
   logic        r_done;
   logic        r_dbz;

   logic        w_signed;
   logic        w_dbz_req;
   logic [31:0] w_mag_a;
   logic [31:0] w_mag_b;
   logic [32:0] w_add;
   logic [63:0] w_mul_step;
   logic [32:0] w_shift;
   logic [32:0] w_diff;
   logic        w_ge;
   logic [63:0] w_div_step;
   logic        w_neg_res;
   logic [63:0] w_prod;
   logic [31:0] w_quo;
   logic [31:0] w_rem;

   assign w_signed  = ~op[0];
   assign w_dbz_req = op[1] && (in_b == 32'd0);
   assign w_mag_a   = (w_signed && in_a[31]) ? (32'd0 - in_a) : in_a;
   assign w_mag_b   = (w_signed && in_b[31]) ? (32'd0 - in_b) : in_b;

   // Multiply: r_acc[31:0] holds the multiplier bits still to consume, upper half accumulates.
   assign w_add      = {1'b0, r_acc[63:32]} + {1'b0, r_opb};
   assign w_mul_step = r_acc[0] ? {w_add, r_acc[31:1]} : {1'b0, r_acc[63:1]};

   // Divide: r_acc[63:32] is the partial remainder, r_acc[31:0] shifts dividend out / quotient in.
   // Remainder < divisor keeps the 33-bit difference's top bit a clean borrow flag.
   assign w_shift    = {r_acc[63:32], r_acc[31]};
   assign w_diff     = w_shift - {1'b0, r_opb};
   assign w_ge       = ~w_diff[32];
   assign w_div_step = {(w_ge ? w_diff[31:0] : w_shift[31:0]), r_acc[30:0], w_ge};

   assign w_neg_res = r_neg_a ^ r_neg_b;
   assign w_prod    = w_neg_res ? (64'd0 - r_acc) : r_acc;
   assign w_quo     = w_neg_res ? (32'd0 - r_acc[31:0]) : r_acc[31:0];
   assign w_rem     = r_neg_a ? (32'd0 - r_acc[63:32]) : r_acc[63:32];

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start && !w_dbz_req) w_next = S_RUN;
         S_RUN:   if (r_cnt == 5'd31) w_next = S_FIX;
         S_FIX:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt    <= 5'd0;
         r_acc    <= 64'd0;
         r_opb    <= 32'd0;
         r_is_div <= 1'b0;
         r_neg_a  <= 1'b0;
         r_neg_b  <= 1'b0;
         r_hi     <= 32'd0;
         r_lo     <= 32'd0;
         r_done   <= 1'b0;
         r_dbz    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_dbz  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  // start wins over MTHI/MTLO in the same cycle
                  if (w_dbz_req) begin
                     r_done <= 1'b1;
                     r_dbz  <= 1'b1;
                  end else begin
                     r_cnt    <= 5'd0;
                     r_acc    <= {32'd0, w_mag_a};
                     r_opb    <= w_mag_b;
                     r_is_div <= op[1];
                     r_neg_a  <= w_signed & in_a[31];
                     r_neg_b  <= w_signed & in_b[31];
                  end
               end else begin
                  if (write_hi) r_hi <= write_data;
                  if (write_lo) r_lo <= write_data;
               end
            end
            S_RUN: begin
               r_cnt <= r_cnt + 5'd1;
               r_acc <= r_is_div ? w_div_step : w_mul_step;
            end
            S_FIX: begin
               r_done <= 1'b1;
               if (r_is_div) begin
                  r_hi <= w_rem;
                  r_lo <= w_quo;
               end else begin
                  r_hi <= w_prod[63:32];
                  r_lo <= w_prod[31:0];
               end
            end
            default: ;
         endcase
      end
   end

   assign busy        = (r_state != S_IDLE);
   assign done        = r_done;
   assign div_by_zero = r_dbz;
   assign hi          = r_hi;
   assign lo          = r_lo;
   assign dbg_state   = r_state;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed plus random checks of mult_div_unit against a 64-bit arithmetic reference model.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_mult_div_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] in_a;
   logic [31:0] in_b;
   logic        write_hi;
   logic        write_lo;
   logic [31:0] write_data;
   logic        busy;
   logic        done;
   logic        div_by_zero;
   logic [31:0] hi;
   logic [31:0] lo;
   logic [1:0]  dbg_state;

   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] exp_hi = 32'd0;
   logic [31:0] exp_lo = 32'd0;

   always #5 clk = ~clk;

   mult_div_unit dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .in_a(in_a), .in_b(in_b),
      .write_hi(write_hi), .write_lo(write_lo), .write_data(write_data),
      .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo),
      .dbg_state(dbg_state)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain signed/unsigned 64-bit arithmetic; SV division truncates toward zero.
   task automatic ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] rh, output logic [31:0] rl);
      longint          sa, sb, sp, sq, sr;
      longint unsigned ua, ub, up, uq, ur;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      rh = 32'd0;
      rl = 32'd0;
      case (o)
         2'd0: begin sp = sa * sb; rh = sp[63:32]; rl = sp[31:0]; end
         2'd1: begin up = ua * ub; rh = up[63:32]; rl = up[31:0]; end
         2'd2: begin sq = sa / sb; sr = sa % sb; rh = sr[31:0]; rl = sq[31:0]; end
         default: begin uq = ua / ub; ur = ua % ub; rh = ur[31:0]; rl = uq[31:0]; end
      endcase
   endtask

   // Starts at a falling edge, returns at the falling edge where done is seen.
   // inject>0 pulses start+write_lo at that cycle of the run; both must be ignored.
   task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int inject);
      int done_n;
      int busy_cnt;
      ref_model(o, a, b, exp_hi, exp_lo);
      start = 1'b1; op = o; in_a = a; in_b = b;
      @(posedge clk);
      done_n   = 0;
      busy_cnt = 0;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (n == 1) begin
            check("done_clears", done, 1'b0);
            start = 1'b0; op = 2'($urandom); in_a = $urandom; in_b = $urandom;
         end
         if (done) begin
            done_n = n;
            break;
         end
         if (busy) busy_cnt++;
         if (n == inject) begin
            start = 1'b1; write_lo = 1'b1; write_data = $urandom;
         end else if (n == inject + 1) begin
            start = 1'b0; write_lo = 1'b0;
         end
      end
      check("done_latency", done_n, 34);
      check("busy_cycles", busy_cnt, 33);
      check("busy_at_done", busy, 1'b0);
      check("dbz_clear", div_by_zero, 1'b0);
      check("hi", hi, exp_hi);
      check("lo", lo, exp_lo);
   endtask

   task automatic do_dbz(input logic [1:0] o, input logic [31:0] a, input logic with_write);
      start = 1'b1; op = o; in_a = a; in_b = 32'd0;
      write_hi = with_write; write_lo = with_write; write_data = $urandom;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0; write_hi = 1'b0; write_lo = 1'b0;
      check("dbz_done", done, 1'b1);
      check("dbz_flag", div_by_zero, 1'b1);
      check("dbz_busy", busy, 1'b0);
      check("dbz_hi", hi, exp_hi);
      check("dbz_lo", lo, exp_lo);
      @(negedge clk);
      check("dbz_done_clear", done, 1'b0);
      check("dbz_flag_clear", div_by_zero, 1'b0);
   endtask

   task automatic do_write(input logic wh, input logic wl, input logic [31:0] data);
      write_hi = wh; write_lo = wl; write_data = data;
      @(posedge clk);
      @(negedge clk);
      write_hi = 1'b0; write_lo = 1'b0;
      if (wh) exp_hi = data;
      if (wl) exp_lo = data;
      check("mt_hi", hi, exp_hi);
      check("mt_lo", lo, exp_lo);
   endtask

   task automatic do_op_reset(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      start = 1'b1; op = o; in_a = a; in_b = b;
      @(posedge clk);
      for (int n = 1; n <= 11; n++) begin
         @(negedge clk);
         start = 1'b0;
      end
      reset = 1'b1;
      #1;
      exp_hi = 32'd0;
      exp_lo = 32'd0;
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_hi", hi, exp_hi);
      check("rst_lo", lo, exp_lo);
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      logic [1:0]  r_o;
      logic [31:0] r_a;
      logic [31:0] r_b;
      reset = 1'b1; start = 1'b0; op = 2'd0; in_a = 32'd0; in_b = 32'd0;
      write_hi = 1'b0; write_lo = 1'b0; write_data = 32'd0;
      repeat (2) @(negedge clk);
      check("reset_busy", busy, 1'b0);
      check("reset_done", done, 1'b0);
      check("reset_dbz", div_by_zero, 1'b0);
      check("reset_hi", hi, 32'd0);
      check("reset_lo", lo, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      do_op(2'd0, 32'hFFFF_FFFF, 32'd5, 0);
      check("mult_neg_hi", hi, 32'hFFFF_FFFF);
      check("mult_neg_lo", lo, 32'hFFFF_FFFB);
      do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      do_op(2'd0, 32'h8000_0000, 32'h8000_0000, 0);
      do_op(2'd2, 32'hFFFF_FFF9, 32'd2, 0);
      check("div_neg_lo", lo, 32'hFFFF_FFFD);
      do_op(2'd3, 32'd7, 32'd2, 0);
      do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      check("div_wrap_lo", lo, 32'h8000_0000);

      do_write(1'b1, 1'b0, 32'h1234_5678);
      do_dbz(2'd3, 32'd9, 1'b0);
      check("dbz_keeps_mthi", hi, 32'h1234_5678);
      do_dbz(2'd2, $urandom, 1'b1);
      do_write(1'b1, 1'b1, $urandom);

      do_op(2'd1, $urandom, $urandom, 6);
      do_op(2'd3, $urandom, 32'd13, 0);

      do_op_reset(2'd0, $urandom, $urandom);
      do_op(2'd2, $urandom, 32'hFFFF_FFF0 | 32'($urandom_range(1, 15)), 0);

      for (int k = 0; k < 16; k++) begin
         r_o = 2'($urandom);
         r_a = $urandom;
         case ($urandom_range(0, 3))
            0:       r_b = 32'd0;
            1:       r_b = 32'($urandom_range(1, 255));
            2:       r_b = 32'hFFFF_FF00 | 32'($urandom_range(0, 255));
            default: r_b = $urandom;
         endcase
         if (r_o[1] && r_b == 32'd0) do_dbz(r_o, r_a, 1'b0);
         else                        do_op(r_o, r_a, r_b, 0);
      end

      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have no parameters; the datapath width SHALL be fixed at 32 bits.
REQ-002 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request to begin the operation selected by op.
REQ-005 op  input  2  operation: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
REQ-006 in_a  input  32  operand A: multiplicand, or dividend (register-bank read port 1).
REQ-007 in_b  input  32  operand B: multiplier, or divisor (register-bank read port 2).
REQ-008 write_hi  input  1  MTHI strobe.
REQ-009 write_lo  input  1  MTLO strobe.
REQ-010 write_data  input  32  data for MTHI/MTLO.
REQ-011 busy  output  1  operation in progress.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 div_by_zero  output  1  asserted with done when a divide had divisor 0.
REQ-014 hi  output  32  HI register: product upper half, or remainder.
REQ-015 lo  output  32  LO register: product lower half, or quotient.

Function
REQ-016 FSM states SHALL be IDLE, RUN and FIX; RUN SHALL use a 5-bit iteration counter.
REQ-017 In IDLE with start=1, the rising edge SHALL accept the request, capture op, in_a and in_b, clear the counter and enter RUN; later operand changes SHALL be ignored.
REQ-018 Both operation classes SHALL operate on magnitudes: absolute values for MULT/DIV, raw values for MULTU/DIVU.
REQ-019 Multiply SHALL use shift-add, one multiplier bit per RUN cycle, with a 64-bit accumulator.
REQ-020 Divide SHALL use restoring division, one quotient bit per RUN cycle, with a 33-bit partial-remainder subtract.
REQ-021 RUN SHALL last exactly 32 cycles; the edge at which the counter equals 31 SHALL enter FIX.
REQ-022 The FIX edge SHALL perform sign correction, write hi and lo, set done=1 and return to IDLE.
REQ-023 Sign correction for MULT SHALL negate the 64-bit product when the operand signs differ.
REQ-024 Sign correction for DIV SHALL negate the quotient when the operand signs differ and give the remainder the sign of the dividend.
REQ-025 Latency: when a request is accepted at edge E, hi, lo and done=1 SHALL be visible after edge E+33.
REQ-026 busy SHALL be 1 from edge E until edge E+33 (33 cycles) and 0 otherwise.
REQ-027 done SHALL be high for exactly one cycle and SHALL clear at the next edge.
REQ-028 DIV or DIVU accepted with in_b=0 SHALL NOT enter RUN.
REQ-029 For such a divide-by-zero request, the next cycle SHALL have done=1 and div_by_zero=1, with busy remaining 0 and hi/lo unchanged.
REQ-030 div_by_zero SHALL clear together with done.
REQ-031 DIV with 0x80000000 / 0xFFFFFFFF SHALL yield lo=0x80000000 and hi=0x00000000, i.e. wrap with no flag.
REQ-032 start SHALL be ignored while busy=1.
REQ-033 write_hi and write_lo SHALL be ignored while busy=1.
REQ-034 In IDLE, write_hi/write_lo SHALL load write_data into hi/lo at the edge; both strobes together SHALL load both registers.
REQ-035 When start and write_hi/write_lo are both asserted in IDLE, start SHALL take priority and the writes SHALL be dropped.
REQ-036 A new start SHALL be accepted in the same cycle that done=1.
REQ-037 hi and lo SHALL be driven directly from registers, with no combinational path from inputs.

Reset
REQ-038 reset=1 SHALL immediately force state=IDLE, counter=0, hi=0, lo=0, busy=0, done=0 and div_by_zero=0.
REQ-039 reset asserted during RUN or FIX SHALL abort the operation with no hi/lo update; after release, the first edge with start=1 SHALL be accepted.

Verification
REQ-040 MULT in_a=0xFFFFFFFF, in_b=5 -> done exactly 33 cycles after accept, hi=0xFFFFFFFF, lo=0xFFFFFFFB, busy high 33 cycles.
REQ-041 MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; MULT 0x80000000*0x80000000 -> hi=0x40000000, lo=0.
REQ-042 DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/2 -> lo=3, hi=1; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-043 After MTHI 0x12345678, DIVU 9/0 -> done and div_by_zero high one cycle after accept, busy never 1, hi stays 0x12345678.
REQ-044 start and write_lo pulsed at RUN cycle 5 -> both ignored, original result intact; back-to-back start on the done cycle -> accepted.
REQ-045 reset asserted at RUN cycle 10 -> busy=0, hi=lo=0 before the next edge; a start after release completes normally in 33 cycles.
